// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter
//
// Measures a slow clock against the fast clock that produced it. For every
// slow period it reports the period and the high time, both counted in
// clk_in cycles, and flags a stable ratio (locked) or a stalled input
// (timeout).
//
// Optional feature macro: CLK_RATIO_DUTY_EN
//   defined   : high-time path present, high_out reports the high time
//   undefined : high-time path removed, high_out tied to 0
//
// Ports
//   clk_in      in   fast reference clock, rising edge
//   rst         in   asynchronous active-low reset
//   slow_in     in   measured clock, asynchronous to clk_in
//   period_out  out  last measured period (clk_in cycles)
//   high_out    out  high time of that period (clk_in cycles)
//   valid       out  one-cycle pulse when period_out/high_out update
//   locked      out  LOCK_COUNT consecutive equal periods seen
//   timeout     out  level, no rising edge for TIMEOUT cycles
//
// state     | meaning
// ----------+-------------------------------------------------
// WAIT_EDGE | after reset, waiting for the first rising edge
// MEASURE   | counting between rising edges
// STALLED   | no rising edge for TIMEOUT cycles, timeout high

module clock_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEASURE   = 2'd1,
        STALLED   = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state;
    state_t             next_state;
    logic [SYNC_STAGES-1:0] sync;
    logic               s;
    logic               s_d;
    logic               rise;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   period_new;
    logic [CNT_W-1:0]   prev_period;
    logic               have_prev;
    logic [3:0]         match_cnt;
    logic [3:0]         match_nxt;

    // Synchronizer plus registered edge strobes on the synchronized bit.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            s_d  <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], slow_in};
            s_d  <= s;
            rise <= s & ~s_d;
        end
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) state <= WAIT_EDGE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_EDGE: if (rise) next_state = MEASURE;
            MEASURE:   if (!rise && cnt == TMO_M1) next_state = STALLED;
            STALLED:   if (rise) next_state = MEASURE;
            default:   next_state = WAIT_EDGE;
        endcase
    end

    always_comb begin
        timeout = (state == STALLED);
    end

    assign period_new = cnt + CNT_ONE;

    // Saturating match count; a valid with no predecessor starts from 0.
    always_comb begin
        match_nxt = 4'd0;
        if (have_prev && period_new == prev_period)
            match_nxt = (match_cnt == LOCK_C) ? match_cnt : match_cnt + 4'd1;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            period_out  <= '0;
            prev_period <= '0;
            have_prev   <= 1'b0;
            match_cnt   <= 4'd0;
            locked      <= 1'b0;
            valid       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == MEASURE) begin
                if (rise) begin
                    cnt         <= '0;
                    valid       <= 1'b1;
                    period_out  <= period_new;
                    prev_period <= period_new;
                    have_prev   <= 1'b1;
                    match_cnt   <= match_nxt;
                    locked      <= (match_nxt == LOCK_C);
                end else begin
                    cnt <= period_new;
                    if (next_state == STALLED) begin
                        have_prev <= 1'b0;
                        match_cnt <= 4'd0;
                        locked    <= 1'b0;
                    end
                end
            end else begin
                cnt       <= '0;
                have_prev <= 1'b0;
                match_cnt <= 4'd0;
                locked    <= 1'b0;
            end
        end
    end

`ifdef CLK_RATIO_DUTY_EN
    logic             fall;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] shadow;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) fall <= 1'b0;
        else      fall <= ~s & s_d;
    end

    // s_d is the level aligned with the rise/fall strobes.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            hcnt     <= '0;
            shadow   <= '0;
            high_out <= '0;
        end else if (state == MEASURE) begin
            if (rise) begin
                hcnt     <= '0;
                high_out <= shadow;
            end else if (s_d) begin
                hcnt <= hcnt + CNT_ONE;
            end
            if (fall) shadow <= hcnt + CNT_ONE;
        end else begin
            hcnt   <= '0;
            shadow <= '0;
        end
    end
`else
    assign high_out = '0;
`endif

endmodule
